// File: rtl/dct_sched.sv
// dct_sched: sequencer for the 8x8 2-D DCT datapath.
// Walks the row pass then the column pass, one MAC term per cycle, drives the
// cos-table indices, the sample-buffer read address and the MAC strobes, and
// tags each finished coefficient for the transpose/output writer.
// Optional feature: define DCT_SCHED_ABORT_EN to add the abort/aborted ports.
module dct_sched #(
  parameter int LAT = 2  // cycles from issue to operands at the MAC input
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
`ifdef DCT_SCHED_ABORT_EN
  input  logic       abort,
  output logic       aborted,
`endif
  output logic       busy,
  output logic       done,
  output logic [2:0] tab_u,
  output logic [2:0] tab_x,
  output logic       src_rd,
  output logic [2:0] src_row,
  output logic [2:0] src_col,
  output logic       mac_clr,
  output logic       mac_en,
  output logic       res_valid,
  output logic       res_pass,
  output logic [2:0] res_line,
  output logic [2:0] res_u
);

  localparam int FW = $clog2(LAT + 2);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  // One issued term as it travels towards the MAC.
  typedef struct packed {
    logic       en;     // a term was issued
    logic       first;  // x == 0: MAC loads instead of accumulating
    logic       last;   // x == 7: coefficient complete after this term
    logic       pass;
    logic [2:0] line;
    logic [2:0] u;
  } term_t;

  state_t            state;
  logic              pass;
  logic [8:0]        cnt;        // {line, u, x} of the next term to issue
  logic [FW-1:0]     flush_cnt;
  logic [2:0]        iss_line;
  term_t [LAT-1:0]   pipe;

  logic              kill;
  logic              issue_now;
  logic [8:0]        issue_term;
  logic              issue_pass;

`ifdef DCT_SCHED_ABORT_EN
  assign kill = abort && (state != IDLE);
`else
  assign kill = 1'b0;
`endif

  // Decide whether a term is issued at the coming edge, and which one.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    issue_now  = 1'b0;
    issue_term = cnt;
    issue_pass = pass;
    case (state)
      IDLE: if (start) begin
        issue_now  = 1'b1;
        issue_term = '0;
        issue_pass = 1'b0;
      end
      RUN:   issue_now = (cnt != 9'd0);  // cnt wraps to 0 after term 511
      FLUSH: if (flush_cnt == FW'(LAT) && !pass) begin
        issue_now  = 1'b1;
        issue_term = '0;
        issue_pass = 1'b1;
      end
      default: ;
    endcase
    if (kill) issue_now = 1'b0;
  end

  // Control FSM, term counters and the registered issue-stage outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      pass      <= 1'b0;
      cnt       <= '0;
      flush_cnt <= '0;
      iss_line  <= '0;
      busy      <= 1'b0;
      src_rd    <= 1'b0;
      tab_u     <= '0;
      tab_x     <= '0;
      src_row   <= '0;
      src_col   <= '0;
`ifdef DCT_SCHED_ABORT_EN
      aborted   <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      src_rd <= issue_now;
      if (issue_now) begin
        cnt      <= issue_term + 9'd1;
        pass     <= issue_pass;
        tab_u    <= issue_term[5:3];
        tab_x    <= issue_term[2:0];
        iss_line <= issue_term[8:6];
        src_row  <= issue_pass ? issue_term[2:0] : issue_term[8:6];
        src_col  <= issue_pass ? issue_term[8:6] : issue_term[2:0];
      end
`ifdef DCT_SCHED_ABORT_EN
      aborted <= kill;
`endif
      if (kill) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: if (start) begin
            state <= RUN;
            busy  <= 1'b1;
          end
          RUN: if (cnt == 9'd0) begin
            state     <= FLUSH;
            flush_cnt <= '0;
          end
          FLUSH: if (flush_cnt == FW'(LAT)) begin
            if (!pass) begin
              state <= RUN;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            flush_cnt <= flush_cnt + 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Delay the issued terms by LAT to the MAC, and one more to the result tag.
  always_ff @(posedge clk) begin
    if (!rst || kill) begin
      // NOTE: the delay pipe is cleared on reset/abort so no stale term can strobe the MAC.
      pipe      <= '0;
      res_valid <= 1'b0;
      res_pass  <= 1'b0;
      res_line  <= '0;
      res_u     <= '0;
      done      <= 1'b0;
    end else begin
      pipe[0] <= '{en: src_rd, first: src_rd && (tab_x == 3'd0),
                   last: src_rd && (tab_x == 3'd7), pass: pass,
                   line: iss_line, u: tab_u};
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
      res_valid <= pipe[LAT-1].last;
      done      <= pipe[LAT-1].last && pipe[LAT-1].pass &&
                   (pipe[LAT-1].line == 3'd7) && (pipe[LAT-1].u == 3'd7);
      if (pipe[LAT-1].last) begin
        res_pass <= pipe[LAT-1].pass;
        res_line <= pipe[LAT-1].line;
        res_u    <= pipe[LAT-1].u;
      end
    end
  end

  assign mac_en  = pipe[LAT-1].en;
  assign mac_clr = pipe[LAT-1].first;

endmodule

// File: tb/tb_dct_sched.sv
// tb_dct_sched: self-checking bench for dct_sched (LAT = 2).
// The reference derives every expected output from the cycle offset since the
// accepted start: term k of a pass is (line,u,x) = (k/64, k/8%8, k%8), row pass
// issues at offsets 1..512, column pass at 516..1027, MAC sees a term LAT later,
// the finished coefficient appears LAT+1 after its x==7 term, done at 1030.
module tb_dct_sched;
  localparam int LAT  = 2;
  localparam int DONE = 2 * (512 + LAT + 1);

  logic       clk = 1'b0;
  logic       rst, start;
  logic       busy, done, src_rd, mac_clr, mac_en, res_valid, res_pass;
  logic [2:0] tab_u, tab_x, src_row, src_col, res_line, res_u;
`ifdef DCT_SCHED_ABORT_EN
  logic       abort, aborted;
  logic       exp_ab;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int rel   = 0;   // model: cycles since accepted start, 0 = idle
  int c_rd, c_en, c_clr, c_res;
  bit seen [2][64];

  dct_sched #(.LAT(LAT)) dut (
    .clk(clk), .rst(rst), .start(start),
`ifdef DCT_SCHED_ABORT_EN
    .abort(abort), .aborted(aborted),
`endif
    .busy(busy), .done(done), .tab_u(tab_u), .tab_x(tab_x),
    .src_rd(src_rd), .src_row(src_row), .src_col(src_col),
    .mac_clr(mac_clr), .mac_en(mac_en), .res_valid(res_valid),
    .res_pass(res_pass), .res_line(res_line), .res_u(res_u)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d (t=%0t rel=%0d)", tag, obs, exp, $time, rel);
    end
  endtask

  // Term index issued at model offset r, or -1; p returns the pass.
  function automatic int term_at(input int r, output int p);
    p = 0;
    if (r >= 1 && r <= 512) return r - 1;
    if (r >= 516 && r <= 1027) begin
      p = 1;
      return r - 516;
    end
    return -1;
  endfunction

  task automatic check_cycle();
    int k, p, km, pm, kr, pr;
    k  = term_at(rel, p);
    km = term_at(rel - LAT, pm);
    kr = term_at(rel - LAT - 1, pr);
    if (kr >= 0 && (kr % 8) != 7) kr = -1;
    check("busy", busy, 32'(rel >= 1 && rel <= DONE));
    check("src_rd", src_rd, 32'(k >= 0));
    if (k >= 0) begin
      check("tab_u", tab_u, (k / 8) % 8);
      check("tab_x", tab_x, k % 8);
      check("src_row", src_row, p ? k % 8 : k / 64);
      check("src_col", src_col, p ? k / 64 : k % 8);
    end
    check("mac_en", mac_en, 32'(km >= 0));
    check("mac_clr", mac_clr, 32'(km >= 0 && (km % 8) == 0));
    check("res_valid", res_valid, 32'(kr >= 0));
    check("done", done, 32'(rel == DONE));
    if (kr >= 0) begin
      check("res_pass", res_pass, pr);
      check("res_line", res_line, kr / 64);
      check("res_u", res_u, (kr / 8) % 8);
    end
`ifdef DCT_SCHED_ABORT_EN
    check("aborted", aborted, exp_ab);
`endif
    if (src_rd === 1'b1)  c_rd++;
    if (mac_en === 1'b1)  c_en++;
    if (mac_clr === 1'b1) c_clr++;
    if (res_valid === 1'b1) begin
      c_res++;
      seen[int'(res_pass)][{res_line, res_u}] = 1'b1;
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, check at negedge.
  task automatic tick(input logic st, input logic rs, input logic ab);
    start = st;
    rst   = rs;
`ifdef DCT_SCHED_ABORT_EN
    abort  = ab;
    exp_ab = 1'b0;
`endif
    @(posedge clk);
    if (!rs) rel = 0;
    else if (ab && rel != 0) begin
      rel = 0;
`ifdef DCT_SCHED_ABORT_EN
      exp_ab = 1'b1;
`endif
    end else if (rel == 0) begin
      if (st) rel = 1;
    end else begin
      rel++;
      if (rel > DONE) rel = 0;
    end
    @(negedge clk);
    check_cycle();
  endtask

  task automatic clear_counts();
    c_rd = 0; c_en = 0; c_clr = 0; c_res = 0;
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < 64; i++) seen[p][i] = 1'b0;
  endtask

  task automatic check_counts(input string tag);
    int n0, n1;
    n0 = 0; n1 = 0;
    for (int i = 0; i < 64; i++) begin
      n0 += int'(seen[0][i]);
      n1 += int'(seen[1][i]);
    end
    check({tag, "_src_rd"}, c_rd, 1024);
    check({tag, "_mac_en"}, c_en, 1024);
    check({tag, "_mac_clr"}, c_clr, 128);
    check({tag, "_res_valid"}, c_res, 128);
    check({tag, "_pairs_pass0"}, n0, 64);
    check({tag, "_pairs_pass1"}, n1, 64);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, busy, 0);      check({tag, "_done"}, done, 0);
    check({tag, "_tab_u"}, tab_u, 0);    check({tag, "_tab_x"}, tab_x, 0);
    check({tag, "_src_rd"}, src_rd, 0);  check({tag, "_src_row"}, src_row, 0);
    check({tag, "_src_col"}, src_col, 0); check({tag, "_mac_en"}, mac_en, 0);
    check({tag, "_mac_clr"}, mac_clr, 0); check({tag, "_res_valid"}, res_valid, 0);
    check({tag, "_res_pass"}, res_pass, 0); check({tag, "_res_line"}, res_line, 0);
    check({tag, "_res_u"}, res_u, 0);
  endtask

  // Start a transform, run until the model is idle again with random start noise.
  task automatic full_run(input string tag);
    int guard;
    clear_counts();
    repeat ($urandom_range(0, 4)) tick(1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    guard = 0;
    while (rel != 0 && guard < 2000) begin
      tick((rel == 600) || ($urandom_range(0, 63) == 0), 1'b1, 1'b0);
      guard++;
    end
    check({tag, "_bounded"}, 32'(guard < 2000), 1);
    check_counts(tag);
  endtask

  // Start a transform and interrupt it at offset r with rst (or abort).
  task automatic cut_run(input int r, input logic use_abort);
    tick(1'b1, 1'b1, 1'b0);
    while (rel != 0 && rel < r) tick($urandom_range(0, 1) == 1, 1'b1, 1'b0);
    tick(1'b0, use_abort, use_abort);
    repeat (8) tick(1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    start = 1'b0;
    rst   = 1'b0;
`ifdef DCT_SCHED_ABORT_EN
    abort  = 1'b0;
    exp_ab = 1'b0;
`endif
    repeat (5) tick(1'b0, 1'b0, 1'b0);
    check_zero("reset");
    repeat (3) tick(1'b0, 1'b1, 1'b0);
    check_zero("idle");

    full_run("run_a");

    cut_run(300, 1'b0);
    cut_run($urandom_range(2, DONE - 1), 1'b0);
    full_run("run_after_rst");

`ifdef DCT_SCHED_ABORT_EN
    cut_run(700, 1'b1);
    tick(1'b0, 1'b1, 1'b1);  // abort while idle: ignored
    full_run("run_after_abort");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
